// File: rtl/nv_ram_fifo_pkg.sv
// rtl/nv_ram_fifo_pkg.sv - shared constants and pointer helper for the 80x36 RAM FIFO controller
package nv_ram_fifo_pkg;

    localparam int DEPTH = 80;
    localparam int AW    = 7;
    localparam int DW    = 36;
    localparam int LVL_W = 7;

    // Depth is not a power of two, so the wrap must be explicit.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

endpackage

// File: rtl/nv_ram_fifo_rdpipe.sv
// rtl/nv_ram_fifo_rdpipe.sv - two-stage RAM read pipeline: address-register and output-register tracking
module nv_ram_fifo_rdpipe (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic pend_nz_i,
    input  logic rd_prdy_i,
    input  logic byp_push_i,
    output logic re_o,
    output logic ore_o,
    output logic a_vld_o,
    output logic out_vld_o
);

    logic a_vld_q, a_vld_d;
    logic out_vld_q, out_vld_d;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            a_vld_q   <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            a_vld_q   <= a_vld_d;
            out_vld_q <= out_vld_d;
        end
    end

    always_comb begin
        a_vld_d   = a_vld_q;
        out_vld_d = out_vld_q;
        if (re_o) begin
            a_vld_d = 1'b1;
        end else if (ore_o) begin
            a_vld_d = 1'b0;
        end
        if (ore_o || byp_push_i) begin
            out_vld_d = 1'b1;
        end else if (rd_prdy_i) begin
            out_vld_d = 1'b0;
        end
    end

    // A new address may be issued when the held one is being captured this cycle.
    always_comb begin
        ore_o     = a_vld_q & (~out_vld_q | rd_prdy_i);
        re_o      = pend_nz_i & (~a_vld_q | ore_o);
        a_vld_o   = a_vld_q;
        out_vld_o = out_vld_q;
    end

endmodule

// File: rtl/nv_ram_fifo_ctrl_80x36.sv
// rtl/nv_ram_fifo_ctrl_80x36.sv - valid/ready FIFO controller for the 80x36 two-port RAM
// Optional write-to-output bypass enabled by defining NV_RAM_FIFO_CTRL_BYPASS_EN.
module nv_ram_fifo_ctrl_80x36
    import nv_ram_fifo_pkg::*;
(
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              wr_pvld,
    output logic              wr_prdy,
    input  logic [DW-1:0]     wr_pd,
    output logic              rd_pvld,
    input  logic              rd_prdy,
    output logic [DW-1:0]     rd_pd,
    output logic [LVL_W-1:0]  fifo_lvl,
    input  logic [31:0]       pwrbus_ram_pd,
    output logic [AW-1:0]     ram_wa,
    output logic              ram_we,
    output logic [DW-1:0]     ram_di,
    output logic [AW-1:0]     ram_ra,
    output logic              ram_re,
    output logic              ram_ore,
    output logic              ram_byp_sel,
    output logic [DW-1:0]     ram_dbyp,
    input  logic [DW-1:0]     ram_dout,
    output logic [31:0]       ram_pwrbus_ram_pd
);

    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LVL_W-1:0] used_q, used_d;
    logic [LVL_W-1:0] pend_q, pend_d;

    logic push, byp, re, ore_ram, a_vld, out_vld;

    // Slots are freed only on capture into the output register, never on re.
    assign wr_prdy = (used_q != FULL);
    assign push    = wr_pvld & wr_prdy;

`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
    assign byp      = push & (pend_q == '0) & ~a_vld & (~out_vld | rd_prdy);
    assign ram_dbyp = byp ? wr_pd : '0;
`else
    assign byp      = 1'b0;
    assign ram_dbyp = '0;
`endif

    nv_ram_fifo_rdpipe u_rdpipe (
        .clk_i      (nvdla_core_clk),
        .rstn_i     (nvdla_core_rstn),
        .pend_nz_i  (pend_q != '0),
        .rd_prdy_i  (rd_prdy),
        .byp_push_i (byp),
        .re_o       (re),
        .ore_o      (ore_ram),
        .a_vld_o    (a_vld),
        .out_vld_o  (out_vld)
    );

    always_comb begin
        wptr_d = ram_we ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = re ? ptr_inc(rptr_q) : rptr_q;
        used_d = used_q + LVL_W'(ram_we) - LVL_W'(ore_ram);
        pend_d = pend_q + LVL_W'(ram_we) - LVL_W'(re);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            used_q <= '0;
            pend_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            used_q <= used_d;
            pend_q <= pend_d;
        end
    end

    assign ram_we            = push & ~byp;
    assign ram_wa            = wptr_q;
    assign ram_di            = wr_pd;
    assign ram_re            = re;
    assign ram_ra            = rptr_q;
    assign ram_ore           = ore_ram | byp;
    assign ram_byp_sel       = byp;
    assign rd_pvld           = out_vld;
    assign rd_pd             = ram_dout;
    assign fifo_lvl          = used_q + LVL_W'(out_vld);
    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_80x36.sv
// tb/tb_nv_ram_fifo_ctrl_80x36.sv - self-checking bench for nv_ram_fifo_ctrl_80x36 with a behavioural 80x36 RAM
module tb_nv_ram_fifo_ctrl_80x36;

`ifdef NV_RAM_FIFO_CTRL_BYPASS_EN
    localparam int EXP_LAT  = 1;
    localparam int EXP_WRAP = 0;
`else
    localparam int EXP_LAT  = 3;
    localparam int EXP_WRAP = 2;
`endif
    localparam logic [35:0] DA = 36'h0_DEAD_BEEF;
    localparam logic [35:0] DB = 36'h1_2345_6789;
    localparam logic [35:0] DC = 36'hF_0000_000F;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wr_pvld, wr_prdy, rd_pvld, rd_prdy;
    logic [35:0] wr_pd, rd_pd, ram_di, ram_dbyp, ram_dout;
    logic [6:0]  fifo_lvl, ram_wa, ram_ra;
    logic        ram_we, ram_re, ram_ore, ram_byp_sel;
    logic [31:0] pwrbus, ram_pwrbus;

    always #5 clk = ~clk;

    nv_ram_fifo_ctrl_80x36 dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rstn),
        .wr_pvld           (wr_pvld),
        .wr_prdy           (wr_prdy),
        .wr_pd             (wr_pd),
        .rd_pvld           (rd_pvld),
        .rd_prdy           (rd_prdy),
        .rd_pd             (rd_pd),
        .fifo_lvl          (fifo_lvl),
        .pwrbus_ram_pd     (pwrbus),
        .ram_wa            (ram_wa),
        .ram_we            (ram_we),
        .ram_di            (ram_di),
        .ram_ra            (ram_ra),
        .ram_re            (ram_re),
        .ram_ore           (ram_ore),
        .ram_byp_sel       (ram_byp_sel),
        .ram_dbyp          (ram_dbyp),
        .ram_dout          (ram_dout),
        .ram_pwrbus_ram_pd (ram_pwrbus)
    );

    // Behavioural RAM: registered read address, output register with enable, bypass mux.
    logic [35:0] mem [0:79];
    logic [6:0]  ra_q;
    logic        ra_live;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
        if (ram_ore) ram_dout <= ram_byp_sel ? ram_dbyp : mem[ra_q];
        if (!rstn) ra_live <= 1'b0;
        else if (ram_re) ra_live <= 1'b1;
        else if (ram_ore) ra_live <= 1'b0;
    end

    typedef struct {
        logic        wv;
        logic [35:0] wd;
        logic        rp;
        logic        e_wrdy;
        logic        e_rdv;
        logic [6:0]  e_lvl;
        logic        e_we;
        logic        e_re;
        logic        e_ore;
        logic        chk_pd;
        logic [35:0] e_pd;
    } vec_t;
    vec_t tbl [10];

    int n_chk = 0, n_err = 0;
    int cyc = 0, pop_cnt = 0, first_pop = -1, last_pop_c = -1;
    int we_full = 0, ovw = 0, lvl_over = 0;
    int wa_wraps = 0, ra_wraps = 0;
    logic have_wa = 0, have_ra = 0;
    logic [6:0] prev_wa, prev_ra;
    logic [35:0] sb [$];
    logic last_acc, last_rdv, last_wrdy, last_we, last_re, last_ore;
    logic [35:0] last_pd;
    logic [6:0]  last_lvl;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with inputs already set; samples mid-cycle, returns at the next negedge.
    task automatic tick();
        #2;
        last_acc  = wr_pvld & wr_prdy;
        last_rdv  = rd_pvld;
        last_pd   = rd_pd;
        last_lvl  = fifo_lvl;
        last_wrdy = wr_prdy;
        last_we   = ram_we;
        last_re   = ram_re;
        last_ore  = ram_ore;
        if (rstn && rd_pvld && rd_prdy) begin
            if (sb.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL rd_extra: got word %0h want no word", rd_pd);
            end else begin
                chk("rd_pd_order", rd_pd, sb.pop_front());
            end
            pop_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop_c = cyc;
        end
        if (rstn && last_acc) sb.push_back(wr_pd);
        if (ram_we && !wr_prdy) we_full++;
        if (ram_we && ra_live && ram_wa == ra_q) ovw++;
        if (fifo_lvl > 7'd81) lvl_over++;
        if (ram_we) begin
            if (have_wa && prev_wa == 7'd79 && ram_wa == 7'd0) wa_wraps++;
            prev_wa = ram_wa; have_wa = 1'b1;
        end
        if (ram_re) begin
            if (have_ra && prev_ra == 7'd79 && ram_ra == 7'd0) ra_wraps++;
            prev_ra = ram_ra; have_ra = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
        tick(); tick();
        rstn = 1'b1;
        sb.delete();
    endtask

    task automatic drain(input string nm);
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        for (int g = 0; g < 120 && sb.size() != 0; g++) tick();
        chk({nm, "_sb_empty"}, sb.size(), 0);
        tick();
        chk({nm, "_rdv_idle"}, last_rdv, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, lat;
        tbl[0] = '{1'b1, DA,    1'b1, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 36'h0};
        tbl[1] = '{1'b0, 36'h0, 1'b1, 1'b1, 1'b0, 7'd1, 1'b0, 1'b1, 1'b0, 1'b0, 36'h0};
        tbl[2] = '{1'b0, 36'h0, 1'b1, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0, 1'b1, 1'b0, 36'h0};
        tbl[3] = '{1'b1, DB,    1'b0, 1'b1, 1'b1, 7'd1, 1'b1, 1'b0, 1'b0, 1'b1, DA};
        tbl[4] = '{1'b1, DC,    1'b0, 1'b1, 1'b1, 7'd2, 1'b1, 1'b1, 1'b0, 1'b1, DA};
        tbl[5] = '{1'b0, 36'h0, 1'b0, 1'b1, 1'b1, 7'd3, 1'b0, 1'b0, 1'b0, 1'b1, DA};
        tbl[6] = '{1'b0, 36'h0, 1'b1, 1'b1, 1'b1, 7'd3, 1'b0, 1'b1, 1'b1, 1'b1, DA};
        tbl[7] = '{1'b0, 36'h0, 1'b1, 1'b1, 1'b1, 7'd2, 1'b0, 1'b0, 1'b1, 1'b1, DB};
        tbl[8] = '{1'b0, 36'h0, 1'b1, 1'b1, 1'b1, 7'd1, 1'b0, 1'b0, 1'b0, 1'b1, DC};
        tbl[9] = '{1'b0, 36'h0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 36'h0};

        rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
        pwrbus = 32'hA5C3_0F1E;
        @(negedge clk);

`ifndef NV_RAM_FIFO_CTRL_BYPASS_EN
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_pvld = tbl[i].wv; wr_pd = tbl[i].wd; rd_prdy = tbl[i].rp;
            tick();
            chk($sformatf("tbl%0d_wr_prdy", i), last_wrdy, tbl[i].e_wrdy);
            chk($sformatf("tbl%0d_rd_pvld", i), last_rdv, tbl[i].e_rdv);
            chk($sformatf("tbl%0d_fifo_lvl", i), last_lvl, tbl[i].e_lvl);
            chk($sformatf("tbl%0d_ram_we", i), last_we, tbl[i].e_we);
            chk($sformatf("tbl%0d_ram_re", i), last_re, tbl[i].e_re);
            chk($sformatf("tbl%0d_ram_ore", i), last_ore, tbl[i].e_ore);
            if (tbl[i].chk_pd) chk($sformatf("tbl%0d_rd_pd", i), last_pd, tbl[i].e_pd);
        end
`endif

        // Single-push latency.
        do_reset();
        chk("rst_wr_prdy", wr_prdy, 1'b1);
        chk("rst_fifo_lvl", fifo_lvl, 7'd0);
        wr_pvld = 1'b1; wr_pd = DA; rd_prdy = 1'b1;
        tick();
        chk("lat_push_acc", last_acc, 1'b1);
        wr_pvld = 1'b0; lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (last_rdv && lat == 0) begin
                lat = k;
                chk("lat_rd_pd", last_pd, DA);
            end
        end
        chk("lat_cycles", lat, EXP_LAT);

        // 200 sequential words with rd_prdy held high.
        do_reset();
        rd_prdy = 1'b1; pop_cnt = 0; first_pop = -1; last_pop_c = -1;
        wa_wraps = 0; ra_wraps = 0; have_wa = 1'b0; have_ra = 1'b0;
        d = 0;
        for (int g = 0; g < 400 && d < 200; g++) begin
            wr_pvld = 1'b1; wr_pd = 36'(d);
            tick();
            if (last_acc) d++;
        end
        drain("seq");
        chk("seq_pops", pop_cnt, 200);
        chk("seq_span", last_pop_c - first_pop, 199);
        chk("seq_wa_wraps", wa_wraps, EXP_WRAP);
        chk("seq_ra_wraps", ra_wraps, EXP_WRAP);

        // Fill with rd_prdy low, then random rd_prdy while pushing at full.
        do_reset();
        d = 0;
        for (int i = 0; i < 90; i++) begin
            wr_pvld = 1'b1; wr_pd = 36'h100 + 36'(d);
            tick();
            if (last_acc) d++;
        end
        chk("fill_accepted", d, 81);
        chk("fill_lvl", last_lvl, 7'd81);
        chk("fill_wr_prdy", last_wrdy, 1'b0);
        for (int i = 0; i < 300; i++) begin
            rd_prdy = 1'($urandom_range(0, 1));
            wr_pvld = 1'b1; wr_pd = 36'h100 + 36'(d);
            tick();
            if (last_acc) d++;
        end
        drain("rand");

        // Push with simultaneous capture while 79 slots are in use.
        do_reset();
        d = 0;
        for (int g = 0; g < 120 && d < 80; g++) begin
            wr_pvld = 1'b1; wr_pd = 36'h7000 + 36'(d);
            tick();
            if (last_acc) d++;
        end
        wr_pvld = 1'b0;
        tick();
        chk("u79_lvl_before", last_lvl, 7'd80);
        wr_pvld = 1'b1; wr_pd = 36'h7FFF; rd_prdy = 1'b1;
        tick();
        chk("u79_push_acc", last_acc, 1'b1);
        chk("u79_ore", last_ore, 1'b1);
        wr_pvld = 1'b0; rd_prdy = 1'b0;
        tick();
        chk("u79_lvl_after", last_lvl, 7'd80);
        chk("u79_wr_prdy", last_wrdy, 1'b1);
        drain("u79");

        // Stall with both pipeline stages full, then write next to rptr.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_pvld = 1'b1; wr_pd = 36'hA00 + 36'(i);
            tick();
        end
        wr_pvld = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 3; i < 5; i++) begin
            wr_pvld = 1'b1; wr_pd = 36'hA00 + 36'(i);
            tick();
        end
        wr_pvld = 1'b0;
        tick();
        chk("stall_lvl", last_lvl, 7'd5);
        pop_cnt = 0;
        drain("stall");
        chk("stall_pops", pop_cnt, 5);

        // Reset with 10 words held.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_pvld = 1'b1; wr_pd = 36'hB00 + 36'(i);
            tick();
        end
        wr_pvld = 1'b0;
        tick();
        chk("mid_lvl_before", last_lvl, 7'd10);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        sb.delete();
        tick();
        chk("mid_rd_pvld", last_rdv, 1'b0);
        chk("mid_fifo_lvl", last_lvl, 7'd0);
        chk("mid_wr_prdy", last_wrdy, 1'b1);
        pop_cnt = 0;
        wr_pvld = 1'b1; wr_pd = 36'h5_A5A5_1234; rd_prdy = 1'b1;
        tick();
        drain("mid");
        chk("mid_pops", pop_cnt, 1);

        chk("no_we_while_full", we_full, 0);
        chk("no_overwrite_ra", ovw, 0);
        chk("lvl_never_over_81", lvl_over, 0);
        chk("pwrbus_pass", ram_pwrbus, pwrbus);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/nv_ram_fifo_ctrl_80x36.md
Name: nv_ram_fifo_ctrl_80x36

Overview:
- Valid/ready FIFO controller that sequences one instance of the 80x36 two-port RAM, which has a registered read address, an output register with its own enable (ore), and a bypass mux.
- Owns the write/read pointers, occupancy, and the two-stage read pipeline (re, then ore).
- Handles backpressure so that no RAM word is overwritten before it has been captured into the output register.
- Used as the generic deep-FIFO wrapper inside NVDLA core sub-units.

Parameters:
- DEPTH, 80, number of RAM entries; pointers wrap from DEPTH-1 to 0 (not a power of two).
- AW, 7, RAM address width.
- DW, 36, payload width.

Ports:
- nvdla_core_clk  in  1  core clock; all state updates on its rising edge.
- nvdla_core_rstn  in  1  reset; synchronous and active-low.
- wr_pvld  in  1  write valid.
- wr_prdy  out  1  write ready.
- wr_pd  in  DW  write payload.
- rd_pvld  out  1  read valid.
- rd_prdy  in  1  read ready.
- rd_pd  out  DW  read payload; driven from ram_dout.
- fifo_lvl  out  7  entries held (RAM-resident plus output register), range 0..DEPTH+1.
- pwrbus_ram_pd  in  32  RAM power-down bus.
- ram_wa  out  AW  RAM write address.
- ram_we  out  1  RAM write enable.
- ram_di  out  DW  RAM write data.
- ram_ra  out  AW  RAM read address.
- ram_re  out  1  RAM read-address register enable.
- ram_ore  out  1  RAM output register enable.
- ram_byp_sel  out  1  RAM bypass select.
- ram_dbyp  out  DW  RAM bypass data.
- ram_dout  in  DW  RAM registered output.
- ram_pwrbus_ram_pd  out  32  equals pwrbus_ram_pd.

Behaviour:
- State:
  - wptr, rptr (AW bits, wrap at DEPTH-1 to 0).
  - used: RAM slots written but not yet captured by ore, 0..DEPTH.
  - pend: slots written but not yet read-issued, 0..used.
  - a_vld: an address is held in the RAM ra_d register.
  - out_vld: the RAM dout register holds an unconsumed word.
- Reset: all state is 0, so rd_pvld=0 and fifo_lvl=0. wr_prdy=1 in the first cycle after reset. RAM contents are not cleared.
- Write:
  - wr_prdy = (used != DEPTH), derived from registered state only.
  - Push = wr_pvld & wr_prdy.
  - On push: ram_we=1, ram_wa=wptr, ram_di=wr_pd; wptr advances; used and pend increment.
- Read pipeline (2 stages):
  - ram_ore = a_vld & (!out_vld | rd_prdy).
  - ram_re = (pend != 0) & (!a_vld | ram_ore); ram_ra = rptr.
  - On re: rptr advances, pend decrements, a_vld is set.
  - On ore without a new re: a_vld clears.
  - On ore: out_vld is set and used decrements.
  - On rd_prdy without ore: out_vld clears.
  - rd_pvld = out_vld; rd_pd = ram_dout.
- Latency and throughput:
  - Write to rd_pvld is 3 cycles in a non-bypass path (push at t, re at t+1, ore at t+2, rd_pvld at t+3).
  - Sustained throughput is 1 word/cycle with rd_prdy held high.
- Hazard rule:
  - A slot is freed only on ore, never on re, so a stalled ra_d can never see its word overwritten.
  - A write in cycle t is readable by re no earlier than t+1 (pend is registered).
- Simultaneous events:
  - Push and ore in the same cycle leave used unchanged.
  - Push and re in the same cycle leave pend unchanged.
  - A push at used==DEPTH-1 with a simultaneous ore is accepted.
- fifo_lvl = used + out_vld.
- ram_byp_sel=0 and ram_dbyp=0 unless the optional feature is enabled.
- Reset mid-operation: all in-flight words are discarded and the block behaves as just after reset in the following cycle.

Optional Feature:
- Macro: NV_RAM_FIFO_CTRL_BYPASS_EN.
- When defined, a bypass push occurs if pend==0 & !a_vld & (!out_vld | rd_prdy) & push.
  - Drive ram_byp_sel=1, ram_dbyp=wr_pd, ram_ore=1, ram_we=0.
  - pend, used and wptr are unchanged; out_vld is set.
  - Write to rd_pvld latency is 1 cycle.
- When undefined, there is no bypass path and ram_byp_sel and ram_dbyp are tied to 0.

Decomposition:
- Shared package nv_ram_fifo_pkg holds:
  - constants DEPTH, AW, DW;
  - the pointer-increment-with-wrap function;
  - the fifo_lvl width constant.
- One natural sub-module, nv_ram_fifo_rdpipe: a_vld/out_vld tracking plus the re/ore generation.
- Pointer and occupancy logic stays in the top level.

Test Plan:
- Reset then a single push (wr_pd=36'h0_DEAD_BEEF) with rd_prdy=1 -> rd_pvld rises exactly 3 cycles after the push with rd_pd=36'h0_DEAD_BEEF. With the bypass macro, it rises 1 cycle after the push.
- Fill with rd_prdy=0 -> 81 words accepted (80 in RAM plus 1 in the output register); wr_prdy=0 and fifo_lvl=81; no ram_we while full.
- Push 200 sequential values 0..199 with rd_prdy=1 -> output is in order, wptr/rptr wrap 79->0 twice, and 1 word/cycle is sustained after fill.
- At fifo_lvl=81, toggle rd_prdy pseudo-randomly while pushing -> no data loss or duplication, and used never exceeds 80. A push together with ore at used==79 leaves used=79.
- Stall with a_vld=1 and out_vld=1, then push to the slot adjacent to rptr -> the stalled word is returned intact, with no overwrite of the captured address.
- Assert nvdla_core_rstn=0 for 1 cycle with 10 words held -> next cycle rd_pvld=0, fifo_lvl=0, wr_prdy=1, and the next push is returned correctly.
